// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
// Grant encoding and cycle-type constants used by the arbiter and its users.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // One-hot owner view of the arbiter state, bit0 = M0, bit1 = M1.
  function automatic logic [1:0] grant_of(input logic [1:0] st);
    return {st == GNT1, st == GNT0};
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle (32-bit data, byte address) with master/slave views.
// Handshake: a beat completes in the cycle where cyc & stb are high together with
// exactly one of ack/err/rty; the master holds stb and its controls until then.
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arb_watchdog.sv
// Per-grant watchdog: counts stb cycles with no slave response and emits a
// one-cycle fire pulse (err to owner, stb masked) after TIMEOUT such cycles.
module wshb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  input  logic stb,
  input  logic resp,
  output logic fire
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // The fire cycle itself masks slave stb, so it never counts as a stall.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt  <= '0;
      fire <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (clear || resp) begin
        cnt <= '0;
      end else if (stb && !fire) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          fire <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Two-master round-robin (or M0-priority) arbiter in front of the SDRAM Wishbone
// slave port; grant is held for a whole bus cycle, hung accesses end with err.
module wshb_sdram_arbiter
  import wshb_arb_pkg::*;
#(
  parameter bit          PRIO_M0 = 1'b0,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  wshb_if.slave            wshb_ifs0,
  wshb_if.slave            wshb_ifs1,
  wshb_if.master           wshb_ifm,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] ack_cnt0,
  output logic [CNT_W-1:0] ack_cnt1,
  output logic             timeout_evt
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_GNT0 = GNT0;
  localparam logic [1:0] ST_GNT1 = GNT1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_m1;
  logic       sel0;
  logic       sel1;
  logic       fire;
  logic       owner_stb;
  logic       slave_resp;
  logic       fwd_ack;
  logic       fwd_err;
  logic       fwd_rty;
  logic       dlv0;
  logic       dlv1;

  // A grant is released only when its owner drops cyc; the other master is
  // then taken directly, otherwise the arbiter rests in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wshb_ifs0.cyc && wshb_ifs1.cyc)
          state_nxt = (PRIO_M0 || last_m1) ? ST_GNT0 : ST_GNT1;
        else if (wshb_ifs0.cyc)
          state_nxt = ST_GNT0;
        else if (wshb_ifs1.cyc)
          state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!wshb_ifs0.cyc)
          state_nxt = wshb_ifs1.cyc ? ST_GNT1 : ST_IDLE;
      end
      ST_GNT1: begin
        if (!wshb_ifs1.cyc)
          state_nxt = wshb_ifs0.cyc ? ST_GNT0 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      last_m1 <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        if (state_nxt == ST_GNT0) last_m1 <= 1'b0;
        if (state_nxt == ST_GNT1) last_m1 <= 1'b1;
      end
    end
  end

  assign sel0  = (state == ST_GNT0);
  assign sel1  = (state == ST_GNT1);
  assign grant = grant_of(state);

  // Request path is purely combinational so a granted cycle sees no wait states.
  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = '0;
    wshb_ifm.dat_ms = '0;
    wshb_ifm.sel    = '0;
    wshb_ifm.cti    = CTI_CLASSIC;
    wshb_ifm.bte    = '0;
    if (sel0) begin
      wshb_ifm.cyc    = wshb_ifs0.cyc;
      wshb_ifm.stb    = wshb_ifs0.stb & ~fire;
      wshb_ifm.we     = wshb_ifs0.we;
      wshb_ifm.adr    = wshb_ifs0.adr;
      wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
      wshb_ifm.sel    = wshb_ifs0.sel;
      wshb_ifm.cti    = wshb_ifs0.cti;
      wshb_ifm.bte    = wshb_ifs0.bte;
    end else if (sel1) begin
      wshb_ifm.cyc    = wshb_ifs1.cyc;
      wshb_ifm.stb    = wshb_ifs1.stb & ~fire;
      wshb_ifm.we     = wshb_ifs1.we;
      wshb_ifm.adr    = wshb_ifs1.adr;
      wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
      wshb_ifm.sel    = wshb_ifs1.sel;
      wshb_ifm.cti    = wshb_ifs1.cti;
      wshb_ifm.bte    = wshb_ifs1.bte;
    end
  end

  // During a watchdog fire the owner sees only err, whatever the slave returns.
  assign fwd_ack = wshb_ifm.ack & ~fire;
  assign fwd_err = wshb_ifm.err | fire;
  assign fwd_rty = wshb_ifm.rty & ~fire;

  assign wshb_ifs0.ack    = sel0 & fwd_ack;
  assign wshb_ifs0.err    = sel0 & fwd_err;
  assign wshb_ifs0.rty    = sel0 & fwd_rty;
  assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;

  assign wshb_ifs1.ack    = sel1 & fwd_ack;
  assign wshb_ifs1.err    = sel1 & fwd_err;
  assign wshb_ifs1.rty    = sel1 & fwd_rty;
  assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

  assign owner_stb  = (sel0 & wshb_ifs0.stb) | (sel1 & wshb_ifs1.stb);
  assign slave_resp = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;

  wshb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (state_nxt != state),
    .stb     (owner_stb),
    .resp    (slave_resp),
    .fire    (fire)
  );

  assign timeout_evt = fire;

  assign dlv0 = sel0 & fwd_ack;
  assign dlv1 = sel1 & fwd_ack;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ack_cnt0 <= '0;
      ack_cnt1 <= '0;
    end else begin
      if (dlv0 && ack_cnt0 != CNT_MAX) ack_cnt0 <= ack_cnt0 + 1'b1;
      if (dlv1 && ack_cnt1 != CNT_MAX) ack_cnt1 <= ack_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Bench for wshb_sdram_arbiter: a round-robin and an M0-priority instance driven by
// burst masters and a slave responder, checked each cycle against an owner/queue model.
module tb_wshb_sdram_arbiter;
  import wshb_arb_pkg::*;

  localparam int T  = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  // tb-side drives, index [dut][master]
  logic        mc [2][2];
  logic        ms [2][2];
  logic        mw [2][2];
  logic [31:0] ma [2][2];
  logic [31:0] md [2][2];
  logic [2:0]  mt [2][2];
  logic        sa [2];
  logic        se [2];
  logic        sr [2];
  logic [31:0] sd [2];

  wire        ack_o [2][2];
  wire        err_o [2][2];
  wire        rty_o [2][2];
  wire [31:0] dsm_o [2][2];
  wire        s_cyc [2];
  wire        s_stb [2];
  wire        s_we  [2];
  wire [31:0] s_adr [2];
  wire [31:0] s_dms [2];
  wire [3:0]  s_sel [2];
  wire [2:0]  s_cti [2];
  wire [1:0]  s_bte [2];
  wire [1:0]    grant_o [2];
  wire [CW-1:0] c0_o [2];
  wire [CW-1:0] c1_o [2];
  wire          tevt_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wshb_if if0 ();
    wshb_if if1 ();
    wshb_if ifm ();

    assign if0.cyc = mc[g][0];  assign if1.cyc = mc[g][1];
    assign if0.stb = ms[g][0];  assign if1.stb = ms[g][1];
    assign if0.we  = mw[g][0];  assign if1.we  = mw[g][1];
    assign if0.adr = ma[g][0];  assign if1.adr = ma[g][1];
    assign if0.dat_ms = md[g][0]; assign if1.dat_ms = md[g][1];
    assign if0.sel = 4'hf;      assign if1.sel = 4'h5;
    assign if0.cti = mt[g][0];  assign if1.cti = mt[g][1];
    assign if0.bte = 2'b00;     assign if1.bte = 2'b00;

    assign ack_o[g][0] = if0.ack;    assign ack_o[g][1] = if1.ack;
    assign err_o[g][0] = if0.err;    assign err_o[g][1] = if1.err;
    assign rty_o[g][0] = if0.rty;    assign rty_o[g][1] = if1.rty;
    assign dsm_o[g][0] = if0.dat_sm; assign dsm_o[g][1] = if1.dat_sm;

    assign ifm.ack = sa[g];
    assign ifm.err = se[g];
    assign ifm.rty = sr[g];
    assign ifm.dat_sm = sd[g];
    assign s_cyc[g] = ifm.cyc;
    assign s_stb[g] = ifm.stb;
    assign s_we[g]  = ifm.we;
    assign s_adr[g] = ifm.adr;
    assign s_dms[g] = ifm.dat_ms;
    assign s_sel[g] = ifm.sel;
    assign s_cti[g] = ifm.cti;
    assign s_bte[g] = ifm.bte;

    wshb_sdram_arbiter #(
      .PRIO_M0 (g == 1),
      .TIMEOUT (T),
      .CNT_W   (CW)
    ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .wshb_ifs0   (if0),
      .wshb_ifs1   (if1),
      .wshb_ifm    (ifm),
      .grant       (grant_o[g]),
      .ack_cnt0    (c0_o[g]),
      .ack_cnt1    (c1_o[g]),
      .timeout_evt (tevt_o[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // master and slave behaviour
  int beats    [2][2];
  int auto_len [2][2];
  bit prev_c   [2][2];
  int mode [2];   // 0 random waits, 1 zero-wait, 2 never respond
  int run  [2];

  // reference model: owner 0 = none, 1 = M0, 2 = M1
  int own   [2];
  int last  [2];
  int stall [2];
  bit fire  [2];
  int ec    [2][2];

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d got=%0h exp=%0h", tag, d, cyc_no, got, exp);
    end
  endtask

  function automatic int pick(int o, int l, bit c0, bit c1, bit prio);
    bit oc;
    bit xc;
    if (o != 0) begin
      oc = (o == 1) ? c0 : c1;
      xc = (o == 1) ? c1 : c0;
      if (oc) return o;
      return xc ? 3 - o : 0;
    end
    if (c0 && c1) return (prio || l == 2) ? 1 : 2;
    if (c0) return 1;
    if (c1) return 2;
    return 0;
  endfunction

  task automatic tb_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        beats[d][i] = 0; auto_len[d][i] = 0; prev_c[d][i] = 1'b0;
        mc[d][i] = 1'b0; ms[d][i] = 1'b0; mw[d][i] = 1'b0;
        ma[d][i] = '0; md[d][i] = '0; mt[d][i] = CTI_CLASSIC;
        ec[d][i] = 0;
      end
      sa[d] = 1'b0; se[d] = 1'b0; sr[d] = 1'b0; sd[d] = '0;
      mode[d] = 1; run[d] = 0;
      own[d] = 0; last[d] = 2; stall[d] = 0; fire[d] = 1'b0;
    end
  endtask

  task automatic check_model(input int d);
    int o;
    int no;
    bit f;
    bit nf;
    bit resp;
    bit dack;
    bit derr;
    logic [1:0] eg;
    o = own[d];
    f = fire[d];
    eg = (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
    chk("grant", d, grant_o[d], eg);
    chk("timeout_evt", d, tevt_o[d], f);
    chk("ack_cnt0", d, c0_o[d], ec[d][0]);
    chk("ack_cnt1", d, c1_o[d], ec[d][1]);
    if (o == 0) begin
      chk("s_cyc", d, s_cyc[d], 0);
      chk("s_stb", d, s_stb[d], 0);
      chk("s_adr", d, s_adr[d], 0);
      chk("s_sel", d, s_sel[d], 0);
    end else begin
      chk("s_cyc", d, s_cyc[d], mc[d][o-1]);
      chk("s_stb", d, s_stb[d], ms[d][o-1] & ~f);
      chk("s_adr", d, s_adr[d], ma[d][o-1]);
      chk("s_dms", d, s_dms[d], md[d][o-1]);
      chk("s_we", d, s_we[d], mw[d][o-1]);
      chk("s_cti", d, s_cti[d], mt[d][o-1]);
      chk("s_sel", d, s_sel[d], (o == 1) ? 4'hf : 4'h5);
    end
    chk("s_bte", d, s_bte[d], 0);
    for (int i = 0; i < 2; i++) begin
      dack = (o == i + 1) && sa[d] && !f;
      derr = (o == i + 1) && (se[d] || f);
      chk($sformatf("ack_m%0d", i), d, ack_o[d][i], dack);
      chk($sformatf("err_m%0d", i), d, err_o[d][i], derr);
      chk($sformatf("rty_m%0d", i), d, rty_o[d][i], 0);
      chk($sformatf("dat_sm_m%0d", i), d, dsm_o[d][i], sd[d]);
      if (dack && ec[d][i] < CMAX) ec[d][i]++;
      if (ack_o[d][i] === 1'b1 && beats[d][i] > 0) beats[d][i]--;
      if (err_o[d][i] === 1'b1) beats[d][i] = 0;
    end
    // stall counter: stb cycles of the owner without any slave response
    resp = sa[d] | se[d] | sr[d];
    nf = 1'b0;
    if (o != 0) begin
      if (resp) stall[d] = 0;
      else if (ms[d][o-1] && !f) begin
        if (stall[d] == T - 1) begin nf = 1'b1; stall[d] = 0; end
        else stall[d]++;
      end
    end
    no = pick(o, last[d], mc[d][0], mc[d][1], d == 1);
    if (no != o) begin
      stall[d] = 0;
      nf = 1'b0;
      if (no != 0) last[d] = no;
    end
    own[d] = no;
    fire[d] = nf;
  endtask

  task automatic cycle();
    bit a;
    @(posedge sys_clk);
    #2;
    cyc_no++;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        if (beats[d][i] == 0 && auto_len[d][i] > 0 && !prev_c[d][i]) beats[d][i] = auto_len[d][i];
        mc[d][i] = (beats[d][i] > 0);
        ms[d][i] = (beats[d][i] > 0);
        mw[d][i] = (i == 1) && (beats[d][i] > 0);
        ma[d][i] = $urandom;
        md[d][i] = $urandom;
        mt[d][i] = (beats[d][i] == 0) ? CTI_CLASSIC : (beats[d][i] == 1) ? CTI_END : CTI_INCR;
        prev_c[d][i] = mc[d][i];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      a = 1'b0;
      if (s_cyc[d] === 1'b1 && s_stb[d] === 1'b1) begin
        if (mode[d] == 1) a = 1'b1;
        else if (mode[d] == 0) a = (run[d] >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        run[d] = a ? 0 : run[d] + 1;
      end else begin
        run[d] = 0;
      end
      sa[d] = a;
      sd[d] = $urandom;
    end
    #1;
    for (int d = 0; d < 2; d++) check_model(d);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((beats[0][0] + beats[0][1] + beats[1][0] + beats[1][1] > 0 ||
            mc[0][0] || mc[0][1] || mc[1][0] || mc[1][1] ||
            grant_o[0] != 2'b00 || grant_o[1] != 2'b00) && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_done", 0, k < budget, 1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tb_clear();
    repeat (2) @(posedge sys_clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", d, grant_o[d], 0);
      chk("rst_s_cyc", d, s_cyc[d], 0);
      chk("rst_tevt", d, tevt_o[d], 0);
      chk("rst_cnt1", d, c1_o[d], 0);
    end
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
  endtask

  initial begin
    int t_stb;
    int t_err;
    bit got_err;

    do_reset();

    // single master 8-beat read burst, zero-wait slave
    beats[0][0] = 8;
    cycle();
    chk("t1_grant_at_rise", 0, grant_o[0], 2'b00);
    cycle();
    chk("t1_grant_next", 0, grant_o[0], 2'b01);
    drain(50);
    chk("t1_ack_cnt0", 0, c0_o[0], 8);
    chk("t1_ack_cnt1", 0, c1_o[0], 0);

    // contention right after reset: M0 first, then alternation
    do_reset();
    beats[0][0] = 4;
    beats[0][1] = 4;
    cycle();
    cycle();
    chk("t2_first_gnt", 0, grant_o[0], 2'b01);
    drain(60);
    beats[0][0] = 2;
    beats[0][1] = 2;
    cycle();
    cycle();
    chk("t2_alternate", 0, grant_o[0], 2'b01);
    drain(60);
    chk("t2_ack_cnt1", 0, c1_o[0], 6);

    // hung slave: err after TIMEOUT stalled stb cycles, M1 waits its turn
    mode[0] = 2;
    beats[0][0] = 1;
    beats[0][1] = 2;
    t_stb = -1;
    t_err = -1;
    got_err = 1'b0;
    for (int k = 0; k < 60 && !got_err; k++) begin
      cycle();
      if (t_stb < 0 && s_stb[0] === 1'b1) t_stb = cyc_no;
      if (err_o[0][0] === 1'b1) begin
        got_err = 1'b1;
        t_err = cyc_no;
        chk("t4_stb_masked", 0, s_stb[0], 0);
        chk("t4_evt", 0, tevt_o[0], 1);
        mode[0] = 1;
      end
    end
    chk("t4_err_seen", 0, got_err, 1);
    chk("t4_latency", 0, t_err - t_stb, T);
    drain(60);

    // randomized traffic: dut0 round-robin, dut1 priority with M1 always requesting
    mode[0] = 0;
    mode[1] = 0;
    auto_len[1][1] = 4;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++)
        if (beats[0][i] == 0 && !prev_c[0][i] && $urandom_range(0, 3) == 0)
          beats[0][i] = $urandom_range(1, 8);
      if (beats[1][0] == 0 && !prev_c[1][0] && $urandom_range(0, 7) == 0)
        beats[1][0] = $urandom_range(1, 4);
      cycle();
    end
    auto_len[1][1] = 0;
    drain(100);
    chk("rand_sat_cnt1", 1, c1_o[1], CMAX);

    // reset in the middle of an M1 burst
    mode[0] = 1;
    beats[0][1] = 8;
    cycle();
    cycle();
    cycle();
    chk("t5_in_gnt1", 0, grant_o[0], 2'b10);
    sys_rst = 1'b1;
    #1;
    chk("t5_grant", 0, grant_o[0], 0);
    chk("t5_s_cyc", 0, s_cyc[0], 0);
    chk("t5_cnt1", 0, c1_o[0], 0);
    tb_clear();
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    beats[0][0] = 3;
    beats[0][1] = 3;
    cycle();
    cycle();
    chk("t5_m0_first", 0, grant_o[0], 2'b01);
    drain(60);

    // saturation of the M1 ack counter
    beats[1][1] = CMAX - 1;
    drain(80);
    chk("t6_cnt_max_m1", 1, c1_o[1], CMAX - 1);
    beats[1][1] = 3;
    drain(40);
    chk("t6_cnt_sat", 1, c1_o[1], CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
